// File: rtl/conv_window_engine_if.sv
// Output pixel stream of the convolution window engine: data plus its output
// coordinates, transferred when out_valid and out_ready are both high.
interface conv_window_engine_if #(
    parameter int WIDTH_BIT = 8,
    parameter int IDX_W     = 3
);
    logic                        out_valid;
    logic                        out_ready;
    logic signed [WIDTH_BIT-1:0] out_data;
    logic [IDX_W-1:0]            out_row;
    logic [IDX_W-1:0]            out_col;

    modport master (
        output out_valid,
        output out_data,
        output out_row,
        output out_col,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_row,
        input  out_col,
        output out_ready
    );
endinterface

// File: rtl/conv_window_engine.sv
// Strided KSIZE x KSIZE convolution over a SIZE x SIZE image, one MAC per cycle,
// with shift/saturate/ReLU post-processing and a valid/ready pixel stream.
module conv_window_engine #(
    parameter int SIZE      = 7,
    parameter int KSIZE     = 3,
    parameter int STRIDE    = 1,
    parameter int WIDTH_BIT = 8,
    parameter int SHIFT     = 0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        relu_en,
    input  logic signed [WIDTH_BIT-1:0] img    [SIZE][SIZE],
    input  logic signed [WIDTH_BIT-1:0] kernel [KSIZE][KSIZE],
    output logic                        busy,
    output logic                        done,
    conv_window_engine_if.master        stream
);
    localparam int OUT_N = (SIZE - KSIZE) / STRIDE + 1;
    localparam int ACC_W = 2 * WIDTH_BIT + $clog2(KSIZE * KSIZE);
    localparam int IDX_W = (OUT_N > 1) ? $clog2(OUT_N) : 1;
    localparam int KI_W  = (KSIZE > 1) ? $clog2(KSIZE) : 1;
    localparam int PIX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-WIDTH_BIT+1){1'b0}}, {(WIDTH_BIT-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, MAC, EMIT, DONE} state_t;

    state_t                      state_reg, state_next;
    logic signed [ACC_W-1:0]     acc_reg, acc_next;
    logic [IDX_W-1:0]            row_reg, row_next;
    logic [IDX_W-1:0]            col_reg, col_next;
    logic [KI_W-1:0]             ki_reg, ki_next;
    logic [KI_W-1:0]             kj_reg, kj_next;
    logic                        relu_reg, relu_next;
    logic signed [WIDTH_BIT-1:0] data_reg, data_next;

    logic [PIX_W-1:0]            r_idx, c_idx;
    logic signed [ACC_W-1:0]     pix_ext, wgt_ext, prod, sum, shifted;
    logic signed [WIDTH_BIT-1:0] sat;

    // Datapath: the operands are widened to ACC_W first so neither product nor sum can wrap.
    always_comb begin
        r_idx   = PIX_W'(int'(row_reg) * STRIDE + int'(ki_reg));
        c_idx   = PIX_W'(int'(col_reg) * STRIDE + int'(kj_reg));
        pix_ext = img[r_idx][c_idx];
        wgt_ext = kernel[ki_reg][kj_reg];
        prod    = pix_ext * wgt_ext;
        sum     = acc_reg + prod;
        shifted = sum >>> SHIFT;
        if (relu_reg && shifted < 0) begin
            sat = '0;
        end else if (shifted > SAT_MAX) begin
            sat = {1'b0, {(WIDTH_BIT-1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            sat = {1'b1, {(WIDTH_BIT-1){1'b0}}};
        end else begin
            sat = shifted[WIDTH_BIT-1:0];
        end
    end

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        row_next   = row_reg;
        col_next   = col_reg;
        ki_next    = ki_reg;
        kj_next    = kj_reg;
        relu_next  = relu_reg;
        data_next  = data_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = MAC;
                    relu_next  = relu_en;
                    acc_next   = '0;
                    row_next   = '0;
                    col_next   = '0;
                    ki_next    = '0;
                    kj_next    = '0;
                end
            end
            MAC: begin
                acc_next = sum;
                if (kj_reg == KI_W'(KSIZE - 1)) begin
                    kj_next = '0;
                    if (ki_reg == KI_W'(KSIZE - 1)) begin
                        ki_next    = '0;
                        state_next = EMIT;
                        data_next  = sat;
                    end else begin
                        ki_next = ki_reg + KI_W'(1);
                    end
                end else begin
                    kj_next = kj_reg + KI_W'(1);
                end
            end
            EMIT: begin
                if (stream.out_ready) begin
                    acc_next   = '0;
                    ki_next    = '0;
                    kj_next    = '0;
                    state_next = MAC;
                    if (col_reg == IDX_W'(OUT_N - 1)) begin
                        col_next = '0;
                        if (row_reg == IDX_W'(OUT_N - 1)) begin
                            row_next   = '0;
                            state_next = DONE;
                        end else begin
                            row_next = row_reg + IDX_W'(1);
                        end
                    end else begin
                        col_next = col_reg + IDX_W'(1);
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            row_reg   <= '0;
            col_reg   <= '0;
            ki_reg    <= '0;
            kj_reg    <= '0;
            relu_reg  <= 1'b0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            row_reg   <= row_next;
            col_reg   <= col_next;
            ki_reg    <= ki_next;
            kj_reg    <= kj_next;
            relu_reg  <= relu_next;
            data_reg  <= data_next;
        end
    end

    // Row/col registers double as the output coordinates; they only move on a handshake.
    assign stream.out_valid = (state_reg == EMIT);
    assign stream.out_data  = data_reg;
    assign stream.out_row   = row_reg;
    assign stream.out_col   = col_reg;
    assign busy             = (state_reg == MAC) || (state_reg == EMIT);
    assign done             = (state_reg == DONE);
endmodule

// File: tb/tb_conv_window_engine.sv
// Directed bench: four engine instances (stride 1/2/3, shift 2) share stimulus;
// each task checks the instance(s) relevant to its scenario.
module tb_conv_window_engine;
    localparam int SIZE  = 7;
    localparam int KSIZE = 3;
    localparam int W     = 8;
    localparam int ND    = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic relu_en = 1'b0;
    logic out_ready = 1'b1;
    logic signed [W-1:0] img    [SIZE][SIZE];
    logic signed [W-1:0] kernel [KSIZE][KSIZE];

    logic                v   [ND];
    logic signed [W-1:0] d   [ND];
    logic [2:0]          r   [ND];
    logic [2:0]          c   [ND];
    logic                bsy [ND];
    logic                dn  [ND];

    int n_checks = 0;
    int n_fail   = 0;

    logic signed [W-1:0] cap_d [ND][25];
    logic [2:0]          cap_r [ND][25];
    logic [2:0]          cap_c [ND][25];
    int cap_n [ND];
    int first_cyc [ND];
    int last_acc [ND];
    int done_cyc [ND];
    int done_cnt [ND];
    int stall_err [ND];

    always #5 clock = ~clock;

    generate
        for (genvar gi = 0; gi < ND; gi++) begin : g_dut
            localparam int ST = (gi == 1) ? 2 : (gi == 2) ? 3 : 1;
            localparam int SH = (gi == 3) ? 2 : 0;
            localparam int ON = (SIZE - KSIZE) / ST + 1;
            localparam int IW = (ON > 1) ? $clog2(ON) : 1;
            conv_window_engine_if #(.WIDTH_BIT(W), .IDX_W(IW)) bus ();
            conv_window_engine #(
                .SIZE(SIZE), .KSIZE(KSIZE), .STRIDE(ST), .WIDTH_BIT(W), .SHIFT(SH)
            ) dut (
                .clock(clock), .reset(reset), .start(start), .relu_en(relu_en),
                .img(img), .kernel(kernel), .busy(bsy[gi]), .done(dn[gi]),
                .stream(bus.master)
            );
            assign bus.out_ready = out_ready;
            assign v[gi] = bus.out_valid;
            assign d[gi] = bus.out_data;
            assign r[gi] = 3'(bus.out_row);
            assign c[gi] = 3'(bus.out_col);
        end
    endgenerate

    task automatic img_diag();
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++)
                img[i][j] = W'(i + j);
    endtask

    task automatic img_fill(input int val);
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++)
                img[i][j] = W'(val);
    endtask

    task automatic kernel_fill(input int val);
        for (int i = 0; i < KSIZE; i++)
            for (int j = 0; j < KSIZE; j++)
                kernel[i][j] = W'(val);
    endtask

    task automatic kernel_single(input int ri, input int ci);
        kernel_fill(0);
        kernel[ri][ci] = 8'sd1;
    endtask

    task automatic wait_idle();
        int n;
        bit idle;
        n = 0;
        idle = 1'b0;
        out_ready = 1'b1;
        start = 1'b0;
        while (!idle && n < 1000) begin
            @(negedge clock);
            n++;
            idle = 1'b1;
            for (int k = 0; k < ND; k++)
                if (bsy[k] || dn[k] || v[k]) idle = 1'b0;
        end
        n_checks++;
        if (!idle) begin
            n_fail++;
            $display("FAIL wait_idle: engines still active after %0d cycles, required idle", n);
        end
    endtask

    // mode 0: out_ready held high; mode 1: out_ready follows 0,0,1.
    task automatic capture(input int mode, input bit extra_start);
        bit                  pv [ND];
        logic signed [W-1:0] pd [ND];
        logic [2:0]          pr [ND];
        logic [2:0]          pc [ND];
        bit prdy;
        bit all_done;
        int cyc;
        for (int k = 0; k < ND; k++) begin
            cap_n[k] = 0; first_cyc[k] = -1; last_acc[k] = -1;
            done_cyc[k] = -1; done_cnt[k] = 0; stall_err[k] = 0;
            pv[k] = 1'b0; pd[k] = '0; pr[k] = '0; pc[k] = '0;
            for (int p = 0; p < 25; p++) begin
                cap_d[k][p] = 'x; cap_r[k][p] = 'x; cap_c[k][p] = 'x;
            end
        end
        prdy = 1'b1;
        all_done = 1'b0;
        cyc = 0;
        @(negedge clock);
        start = 1'b1;
        while (!all_done && cyc < 2000) begin
            @(negedge clock);
            cyc++;
            start = extra_start && (cyc == 25);
            out_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 2);
            all_done = 1'b1;
            for (int k = 0; k < ND; k++) begin
                if (pv[k] && !prdy &&
                    (v[k] !== 1'b1 || d[k] !== pd[k] || r[k] !== pr[k] || c[k] !== pc[k]))
                    stall_err[k]++;
                if (v[k] && first_cyc[k] < 0) first_cyc[k] = cyc;
                if (v[k] && out_ready) begin
                    if (cap_n[k] < 25) begin
                        cap_d[k][cap_n[k]] = d[k];
                        cap_r[k][cap_n[k]] = r[k];
                        cap_c[k][cap_n[k]] = c[k];
                    end
                    cap_n[k]++;
                    last_acc[k] = cyc;
                end
                if (dn[k]) begin
                    done_cnt[k]++;
                    if (done_cyc[k] < 0) done_cyc[k] = cyc;
                end
                if (done_cyc[k] < 0 || cyc <= done_cyc[k] + 1) all_done = 1'b0;
                pv[k] = v[k]; pd[k] = d[k]; pr[k] = r[k]; pc[k] = c[k];
            end
            prdy = out_ready;
        end
        start = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (!all_done) begin
            n_fail++;
            $display("FAIL capture_timeout: run not finished after %0d cycles", cyc);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        for (int k = 0; k < ND; k++) begin
            n_checks++;
            if (v[k] !== 1'b0 || bsy[k] !== 1'b0 || dn[k] !== 1'b0 ||
                d[k] !== 8'sd0 || r[k] !== 3'd0 || c[k] !== 3'd0) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: valid=%b busy=%b done=%b data=%0d row=%0d col=%0d, required all 0",
                         k, v[k], bsy[k], dn[k], d[k], r[k], c[k]);
            end
        end
        reset = 1'b0;
        $display("test_reset: done");
    endtask

    task automatic test_identity();
        logic signed [W-1:0] exp_d;
        wait_idle();
        img_diag();
        kernel_single(1, 1);
        relu_en = 1'b0;
        capture(0, 1'b0);
        n_checks++;
        if (cap_n[0] !== 25) begin
            n_fail++;
            $display("FAIL identity_count: got %0d pixels, required 25", cap_n[0]);
        end
        for (int p = 0; p < 25; p++) begin
            exp_d = W'(p / 5 + p % 5 + 2);
            n_checks++;
            if (cap_d[0][p] !== exp_d || cap_r[0][p] !== 3'(p / 5) || cap_c[0][p] !== 3'(p % 5)) begin
                n_fail++;
                $display("FAIL identity_pix %0d: got (%0d,%0d)=%0d, required (%0d,%0d)=%0d",
                         p, cap_r[0][p], cap_c[0][p], cap_d[0][p], p / 5, p % 5, exp_d);
            end
            exp_d = W'((p / 5 + p % 5 + 2) / 4);
            n_checks++;
            if (cap_d[3][p] !== exp_d) begin
                n_fail++;
                $display("FAIL shift_identity_pix %0d: got %0d, required %0d", p, cap_d[3][p], exp_d);
            end
        end
        n_checks++;
        if (first_cyc[0] !== 10) begin
            n_fail++;
            $display("FAIL first_valid_latency: got %0d cycles, required 10", first_cyc[0]);
        end
        n_checks++;
        if (last_acc[0] !== 250) begin
            n_fail++;
            $display("FAIL throughput_last_accept: got cycle %0d, required 250", last_acc[0]);
        end
        n_checks++;
        if (done_cyc[0] !== last_acc[0] + 1 || done_cnt[0] !== 1) begin
            n_fail++;
            $display("FAIL done_pulse: got cycle %0d count %0d, required cycle %0d count 1",
                     done_cyc[0], done_cnt[0], last_acc[0] + 1);
        end
        $display("test_identity: %0d pixels captured", cap_n[0]);
    endtask

    task automatic test_stride();
        logic signed [W-1:0] exp_d;
        wait_idle();
        img_diag();
        kernel_single(0, 0);
        relu_en = 1'b0;
        capture(0, 1'b0);
        n_checks++;
        if (cap_n[1] !== 9 || done_cnt[1] !== 1) begin
            n_fail++;
            $display("FAIL stride2_count: got %0d pixels %0d dones, required 9 and 1", cap_n[1], done_cnt[1]);
        end
        for (int p = 0; p < 9; p++) begin
            exp_d = W'(2 * (p / 3) + 2 * (p % 3));
            n_checks++;
            if (cap_d[1][p] !== exp_d || cap_r[1][p] !== 3'(p / 3) || cap_c[1][p] !== 3'(p % 3)) begin
                n_fail++;
                $display("FAIL stride2_pix %0d: got (%0d,%0d)=%0d, required (%0d,%0d)=%0d",
                         p, cap_r[1][p], cap_c[1][p], cap_d[1][p], p / 3, p % 3, exp_d);
            end
        end
        n_checks++;
        if (cap_n[2] !== 4 || done_cnt[2] !== 1) begin
            n_fail++;
            $display("FAIL stride3_count: got %0d pixels %0d dones, required 4 and 1", cap_n[2], done_cnt[2]);
        end
        for (int p = 0; p < 4; p++) begin
            exp_d = W'(3 * (p / 2) + 3 * (p % 2));
            n_checks++;
            if (cap_d[2][p] !== exp_d || cap_r[2][p] !== 3'(p / 2) || cap_c[2][p] !== 3'(p % 2)) begin
                n_fail++;
                $display("FAIL stride3_pix %0d: got (%0d,%0d)=%0d, required (%0d,%0d)=%0d",
                         p, cap_r[2][p], cap_c[2][p], cap_d[2][p], p / 2, p % 2, exp_d);
            end
        end
        $display("test_stride: %0d and %0d pixels captured", cap_n[1], cap_n[2]);
    endtask

    task automatic test_saturation();
        int img_v [3];
        bit relu_v [3];
        int exp_v [3];
        img_v = '{127, -128, -128};
        relu_v = '{1'b0, 1'b0, 1'b1};
        exp_v = '{127, -128, 0};
        for (int t = 0; t < 3; t++) begin
            wait_idle();
            img_fill(img_v[t]);
            kernel_fill(1);
            relu_en = relu_v[t];
            capture(0, 1'b0);
            for (int k = 0; k < ND; k += 3) begin
                n_checks++;
                if (cap_n[k] !== 25) begin
                    n_fail++;
                    $display("FAIL sat_count case%0d dut%0d: got %0d, required 25", t, k, cap_n[k]);
                end
                for (int p = 0; p < 25; p++) begin
                    n_checks++;
                    if (cap_d[k][p] !== W'(exp_v[t])) begin
                        n_fail++;
                        $display("FAIL sat_pix case%0d dut%0d p%0d: got %0d, required %0d",
                                 t, k, p, cap_d[k][p], exp_v[t]);
                    end
                end
            end
            $display("test_saturation: img=%0d relu=%0b checked", img_v[t], relu_v[t]);
        end
        relu_en = 1'b0;
    endtask

    task automatic test_shift();
        int kv [2];
        kv = '{1, -1};
        for (int t = 0; t < 2; t++) begin
            wait_idle();
            img_fill(4);
            kernel_fill(kv[t]);
            relu_en = 1'b0;
            capture(0, 1'b0);
            for (int p = 0; p < 25; p++) begin
                n_checks++;
                if (cap_d[3][p] !== W'(9 * kv[t]) || cap_d[0][p] !== W'(36 * kv[t])) begin
                    n_fail++;
                    $display("FAIL shift_pix k=%0d p%0d: got %0d/%0d, required %0d/%0d",
                             kv[t], p, cap_d[3][p], cap_d[0][p], 9 * kv[t], 36 * kv[t]);
                end
            end
            $display("test_shift: kernel=%0d checked", kv[t]);
        end
    endtask

    task automatic test_backpressure();
        logic signed [W-1:0] exp_d;
        wait_idle();
        img_diag();
        kernel_single(1, 1);
        relu_en = 1'b0;
        capture(1, 1'b0);
        n_checks++;
        if (cap_n[0] !== 25 || done_cnt[0] !== 1) begin
            n_fail++;
            $display("FAIL bp_count: got %0d pixels %0d dones, required 25 and 1", cap_n[0], done_cnt[0]);
        end
        for (int p = 0; p < 25; p++) begin
            exp_d = W'(p / 5 + p % 5 + 2);
            n_checks++;
            if (cap_d[0][p] !== exp_d || cap_r[0][p] !== 3'(p / 5) || cap_c[0][p] !== 3'(p % 5)) begin
                n_fail++;
                $display("FAIL bp_pix %0d: got (%0d,%0d)=%0d, required (%0d,%0d)=%0d",
                         p, cap_r[0][p], cap_c[0][p], cap_d[0][p], p / 5, p % 5, exp_d);
            end
        end
        for (int k = 0; k < ND; k++) begin
            n_checks++;
            if (stall_err[k] !== 0) begin
                n_fail++;
                $display("FAIL bp_stable dut%0d: %0d stalled cycles changed outputs, required 0", k, stall_err[k]);
            end
        end
        $display("test_backpressure: %0d pixels captured", cap_n[0]);
    endtask

    task automatic test_back_to_back();
        logic signed [W-1:0] exp_d;
        wait_idle();
        img_diag();
        kernel_single(1, 1);
        @(negedge clock);
        start = 1'b1;
        for (int cyc = 1; cyc <= 115; cyc++) begin
            @(negedge clock);
            start = 1'b0;
        end
        n_checks++;
        if (bsy[0] !== 1'b1 || v[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_run_state: busy=%b valid=%b, required busy=1 valid=0", bsy[0], v[0]);
        end
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if (v[0] !== 1'b0 || bsy[0] !== 1'b0 || dn[0] !== 1'b0 || d[0] !== 8'sd0) begin
            n_fail++;
            $display("FAIL mid_run_reset: valid=%b busy=%b done=%b data=%0d, required 0 0 0 0",
                     v[0], bsy[0], dn[0], d[0]);
        end
        reset = 1'b0;
        wait_idle();
        capture(0, 1'b1);
        n_checks++;
        if (cap_n[0] !== 25 || done_cnt[0] !== 1 || last_acc[0] !== 250) begin
            n_fail++;
            $display("FAIL restart_run: got %0d pixels %0d dones last=%0d, required 25 1 250",
                     cap_n[0], done_cnt[0], last_acc[0]);
        end
        for (int p = 0; p < 25; p++) begin
            exp_d = W'(p / 5 + p % 5 + 2);
            n_checks++;
            if (cap_d[0][p] !== exp_d || cap_r[0][p] !== 3'(p / 5) || cap_c[0][p] !== 3'(p % 5)) begin
                n_fail++;
                $display("FAIL restart_pix %0d: got (%0d,%0d)=%0d, required (%0d,%0d)=%0d",
                         p, cap_r[0][p], cap_c[0][p], cap_d[0][p], p / 5, p % 5, exp_d);
            end
        end
        $display("test_back_to_back: %0d pixels after restart", cap_n[0]);
    endtask

    initial begin
        img_fill(0);
        kernel_fill(0);
        test_reset();
        test_identity();
        test_stride();
        test_saturation();
        test_shift();
        test_backpressure();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
